// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshakes, CPU stall and the shared data-memory port
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic req0_valid, req0_we, req0_ready, rsp0_valid;
  logic req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [ADDR_WIDTH-1:0] req0_addr, req1_addr, mem_addr;
  logic [DATA_WIDTH-1:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata, mem_wdata, mem_rdata;
  logic cpu_stall, mem_en, mem_we;
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata, mem_rdata,
    output req0_ready, rsp0_valid, rsp0_rdata, req1_ready, rsp1_valid, rsp1_rdata,
    output cpu_stall, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata, mem_rdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, req1_ready, rsp1_valid, rsp1_rdata,
    input  cpu_stall, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter of a CPU and a loader port onto one fixed-latency data memory
module dmem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input logic clk,
  input logic rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic gnt_q, gnt_d, last_gnt_q, last_gnt_d, we_q, we_d;
  logic [1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic pick1, acc0, acc1;
  // on a tie the requester that lost the previous grant wins
  assign pick1 = bus.req1_valid && (!bus.req0_valid || !last_gnt_q);
  assign acc0 = bus.req0_valid && bus.req0_ready;
  assign acc1 = bus.req1_valid && bus.req1_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q <= 1'b0;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_gnt_q <= last_gnt_d;
      we_q <= we_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_gnt_d = last_gnt_q;
    we_d = we_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: if (acc0 || acc1) begin
        state_d = ISSUE;
        gnt_d = acc1;
        last_gnt_d = acc1;
        we_d = acc1 ? bus.req1_we : bus.req0_we;
        addr_d = acc1 ? bus.req1_addr : bus.req0_addr;
        wdata_d = acc1 ? bus.req1_wdata : bus.req0_wdata;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = 2'(MEM_LATENCY - 1);
      end
      WAIT: if (cnt_q == '0) begin
        state_d = RESP;
        rdata0_d = gnt_q ? rdata0_q : (we_q ? '0 : bus.mem_rdata);
        rdata1_d = gnt_q ? (we_q ? '0 : bus.mem_rdata) : rdata1_q;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.req0_ready = !rst && state_q == IDLE && bus.req0_valid && !pick1;
    bus.req1_ready = !rst && state_q == IDLE && pick1;
    bus.cpu_stall = bus.req0_valid && !bus.req0_ready;
    bus.mem_en = !rst && state_q == ISSUE;
    bus.mem_we = bus.mem_en && we_q;
    bus.mem_addr = addr_q;
    bus.mem_wdata = wdata_q;
    bus.rsp0_valid = !rst && state_q == RESP && !gnt_q;
    bus.rsp1_valid = !rst && state_q == RESP && gnt_q;
    bus.rsp0_rdata = rdata0_q;
    bus.rsp1_rdata = rdata1_q;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for the arbiter at latency 2, plus latency-1 and latency-4 instances
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  typedef struct {
    bit id;
    bit we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int t;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  txn_t sb[$];
  logic [DW-1:0] env_mem [256];
  bit env_wr [256];
  logic [DW-1:0] ref_mem [256];
  bit ref_wr [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();
  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b4 ();
  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(b2));
  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(1)) dut_l1 (.clk(clk), .rst(rst), .bus(b1));
  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(4)) dut_l4 (.clk(clk), .rst(rst), .bus(b4));

  assign b1.mem_rdata = 32'hC0DE_0001;
  assign b4.mem_rdata = 32'hC0DE_0004;

  function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  // memory returns data registered at the ISSUE edge, valid through every WAIT cycle
  always @(posedge clk) begin
    if (b2.mem_en) begin
      b2.mem_rdata <= env_wr[b2.mem_addr[9:2]] ? env_mem[b2.mem_addr[9:2]] : seed(b2.mem_addr);
      if (b2.mem_we) begin
        env_mem[b2.mem_addr[9:2]] <= b2.mem_wdata;
        env_wr[b2.mem_addr[9:2]] <= 1'b1;
      end
    end
  end

  task automatic monitor();
    txn_t x;
    logic [7:0] idx;
    logic [DW-1:0] got;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        checks++;
        if (b2.req0_ready || b2.req1_ready || b2.mem_en || b2.mem_we || b2.rsp0_valid || b2.rsp1_valid || b2.cpu_stall !== b2.req0_valid) begin
          errors++;
          $display("FAIL reset_outputs got rdy=%b%b en=%b we=%b rsp=%b%b stall=%b, required all 0 and stall=%b",
                   b2.req0_ready, b2.req1_ready, b2.mem_en, b2.mem_we, b2.rsp0_valid, b2.rsp1_valid, b2.cpu_stall, b2.req0_valid);
        end
      end else begin
        checks++;
        if (b2.cpu_stall !== (b2.req0_valid && !b2.req0_ready) || (b2.req0_ready && b2.req1_ready) || (b2.mem_we && !b2.mem_en)) begin
          errors++;
          $display("FAIL protocol cyc=%0d got stall=%b rdy=%b%b en=%b we=%b", cyc, b2.cpu_stall, b2.req0_ready, b2.req1_ready, b2.mem_en, b2.mem_we);
        end
        if ((b2.req0_valid && b2.req0_ready) || (b2.req1_valid && b2.req1_ready)) begin
          x.id = b2.req1_ready;
          x.we = x.id ? b2.req1_we : b2.req0_we;
          x.addr = x.id ? b2.req1_addr : b2.req0_addr;
          x.wdata = x.id ? b2.req1_wdata : b2.req0_wdata;
          idx = x.addr[9:2];
          x.rdata = x.we ? '0 : (ref_wr[idx] ? ref_mem[idx] : seed(x.addr));
          if (x.we) begin
            ref_mem[idx] = x.wdata;
            ref_wr[idx] = 1'b1;
          end
          x.t = cyc;
          sb.push_back(x);
        end
        if (b2.mem_en) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL mem_en_unexpected cyc=%0d addr=%h, required no access", cyc, b2.mem_addr);
          end else if (cyc != sb[0].t + 1 || b2.mem_we !== sb[0].we || b2.mem_addr !== sb[0].addr || b2.mem_wdata !== sb[0].wdata) begin
            errors++;
            $display("FAIL mem_access got cyc=%0d we=%b addr=%h wdata=%h, required cyc=%0d we=%b addr=%h wdata=%h",
                     cyc, b2.mem_we, b2.mem_addr, b2.mem_wdata, sb[0].t + 1, sb[0].we, sb[0].addr, sb[0].wdata);
          end
        end
        if (b2.rsp0_valid || b2.rsp1_valid) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected cyc=%0d got rsp=%b%b, required none", cyc, b2.rsp0_valid, b2.rsp1_valid);
          end else begin
            x = sb.pop_front();
            got = x.id ? b2.rsp1_rdata : b2.rsp0_rdata;
            if ((b2.rsp0_valid && b2.rsp1_valid) || b2.rsp1_valid !== x.id || cyc != x.t + 4 || got !== x.rdata) begin
              errors++;
              $display("FAIL rsp_match got cyc=%0d rsp=%b%b data=%h, required cyc=%0d id=%0d data=%h",
                       cyc, b2.rsp0_valid, b2.rsp1_valid, got, x.t + 4, x.id, x.rdata);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_sig(input int which, output int t);
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clk);
      if ((which == 0 && b2.req0_ready) || (which == 1 && b2.req1_ready) ||
          (which == 2 && b2.rsp0_valid) || (which == 3 && b2.rsp1_valid)) t = cyc;
    end
    checks++;
    if (t < 0) begin
      errors++;
      $display("FAIL wait_timeout sel=%0d got no event, required one within 20 cycles", which);
    end
  endtask

  task automatic drive_req(input bit id, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata, output int t);
    @(posedge clk); #1;
    if (id) begin
      b2.req1_valid = 1'b1; b2.req1_we = we; b2.req1_addr = addr; b2.req1_wdata = wdata;
    end else begin
      b2.req0_valid = 1'b1; b2.req0_we = we; b2.req0_addr = addr; b2.req0_wdata = wdata;
    end
    wait_sig(id ? 1 : 0, t);
    @(posedge clk); #1;
    if (id) b2.req1_valid = 1'b0;
    else b2.req0_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (b2.rsp0_rdata !== '0 || b2.rsp1_rdata !== '0 || b2.mem_addr !== '0 || b2.mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data got rdata=%h/%h addr=%h wdata=%h, required all 0", b2.rsp0_rdata, b2.rsp1_rdata, b2.mem_addr, b2.mem_wdata);
    end
    #1 b2.req0_valid = 1'b1;
    #1;
    checks++;
    if (b2.cpu_stall !== 1'b1 || b2.req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got stall=%b ready=%b, required stall=1 ready=0", b2.cpu_stall, b2.req0_ready);
    end
    b2.req0_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_cpu_read();
    int t, tr;
    drive_req(0, 0, 32'h10, '0, t);
    wait_sig(2, tr);
    checks++;
    if (tr != t + 4 || b2.rsp0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cpu_read got cyc=%0d data=%h, required cyc=%0d data=deadbeef", tr, b2.rsp0_rdata, t + 4);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (b2.rsp0_valid !== 1'b0 || b2.rsp0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cpu_read_hold got valid=%b data=%h, required valid=0 data=deadbeef", b2.rsp0_valid, b2.rsp0_rdata);
    end
  endtask

  task automatic test_loader_write();
    int t, tr;
    drive_req(1, 1, 32'h20, 32'h55, t);
    @(negedge clk);
    checks++;
    if (b2.mem_en !== 1'b1 || b2.mem_we !== 1'b1 || b2.mem_addr !== 32'h20 || b2.mem_wdata !== 32'h55) begin
      errors++;
      $display("FAIL write_issue got en=%b we=%b addr=%h wdata=%h, required 1 1 20 55", b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (b2.mem_en !== 1'b0 || b2.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL write_single got en=%b we=%b, required 0 0", b2.mem_en, b2.mem_we);
    end
    wait_sig(3, tr);
    checks++;
    if (tr != t + 4 || b2.rsp1_rdata !== '0 || b2.rsp0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_rsp got cyc=%0d rdata1=%h rdata0=%h, required cyc=%0d rdata1=0 rdata0=deadbeef", tr, b2.rsp1_rdata, b2.rsp0_rdata, t + 4);
    end
    drive_req(0, 0, 32'h20, '0, t);
    wait_sig(2, tr);
    checks++;
    if (b2.rsp0_rdata !== 32'h55) begin
      errors++;
      $display("FAIL readback got %h, required 55", b2.rsp0_rdata);
    end
  endtask

  task automatic test_round_robin();
    int ids[4];
    int ts[4];
    int n = 0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    b2.req0_valid = 1'b1; b2.req0_we = 1'b0; b2.req0_addr = 32'h40;
    b2.req1_valid = 1'b1; b2.req1_we = 1'b0; b2.req1_addr = 32'h44;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (b2.req0_ready || b2.req1_ready) begin
        ids[n] = b2.req1_ready ? 1 : 0;
        ts[n] = cyc;
        n++;
        if (b2.req1_ready) begin
          checks++;
          if (b2.cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL rr_stall got %b, required 1", b2.cpu_stall);
          end
        end
      end
    end
    @(posedge clk); #1 b2.req0_valid = 1'b0; b2.req1_valid = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_count got %0d grants, required 4", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (ids[k] != k % 2 || (k > 0 && ts[k] - ts[k - 1] != 5)) begin
        errors++;
        $display("FAIL rr_order grant %0d got id=%0d gap=%0d, required id=%0d gap=5", k, ids[k], k > 0 ? ts[k] - ts[k - 1] : 5, k % 2);
      end
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset_abort();
    int t, r, tr;
    drive_req(0, 0, 32'h48, '0, t);
    @(posedge clk); #1;
    rst = 1'b1;
    b2.req0_valid = 1'b1; b2.req0_we = 1'b0; b2.req0_addr = 32'h10;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    r = cyc;
    checks++;
    if (b2.req0_ready !== 1'b1 || b2.rsp0_valid !== 1'b0 || b2.rsp0_rdata !== '0) begin
      errors++;
      $display("FAIL abort_release got ready=%b rsp=%b rdata=%h, required 1 0 0", b2.req0_ready, b2.rsp0_valid, b2.rsp0_rdata);
    end
    @(posedge clk); #1 b2.req0_valid = 1'b0;
    wait_sig(2, tr);
    checks++;
    if (tr != r + 4 || b2.rsp0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL abort_next got cyc=%0d data=%h, required cyc=%0d data=deadbeef", tr, b2.rsp0_rdata, r + 4);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_addr_change();
    int t, t2, tr;
    @(posedge clk); #1;
    b2.req0_valid = 1'b1; b2.req0_we = 1'b0; b2.req0_addr = 32'h30;
    wait_sig(0, t);
    @(posedge clk); #1;
    @(posedge clk); #1 b2.req0_addr = 32'h34;
    @(negedge clk);
    checks++;
    if (b2.mem_addr !== 32'h30) begin
      errors++;
      $display("FAIL addr_hold got %h, required 30", b2.mem_addr);
    end
    wait_sig(0, t2);
    @(posedge clk); #1 b2.req0_valid = 1'b0;
    checks++;
    if (t2 != t + 5) begin
      errors++;
      $display("FAIL addr_reaccept got cyc=%0d, required %0d", t2, t + 5);
    end
    wait_sig(2, tr);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_latency_sweep();
    int t;
    int n1 = 0, n4 = 0, e1 = -1, e4 = -1, r1 = -1, r4 = -1;
    logic [DW-1:0] d1 = '0, d4 = '0;
    @(posedge clk); #1;
    b1.req0_valid = 1'b1; b1.req0_we = 1'b0; b1.req0_addr = 32'h8;
    b4.req0_valid = 1'b1; b4.req0_we = 1'b0; b4.req0_addr = 32'h8;
    @(negedge clk);
    t = cyc;
    checks++;
    if (b1.req0_ready !== 1'b1 || b4.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL sweep_accept got %b %b, required 1 1", b1.req0_ready, b4.req0_ready);
    end
    @(posedge clk); #1 b1.req0_valid = 1'b0; b4.req0_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b1.mem_en) begin n1++; e1 = cyc; end
      if (b4.mem_en) begin n4++; e4 = cyc; end
      if (b1.rsp0_valid) begin r1 = cyc; d1 = b1.rsp0_rdata; end
      if (b4.rsp0_valid) begin r4 = cyc; d4 = b4.rsp0_rdata; end
    end
    checks++;
    if (n1 != 1 || e1 != t + 1 || r1 != t + 3 || d1 !== 32'hC0DE_0001) begin
      errors++;
      $display("FAIL lat1 got en_count=%0d en=%0d rsp=%0d data=%h, required 1 %0d %0d c0de0001", n1, e1, r1, d1, t + 1, t + 3);
    end
    checks++;
    if (n4 != 1 || e4 != t + 1 || r4 != t + 6 || d4 !== 32'hC0DE_0004) begin
      errors++;
      $display("FAIL lat4 got en_count=%0d en=%0d rsp=%0d data=%h, required 1 %0d %0d c0de0004", n4, e4, r4, d4, t + 1, t + 6);
    end
  endtask

  initial begin
    b2.req0_valid = 1'b0; b2.req0_we = 1'b0; b2.req0_addr = '0; b2.req0_wdata = '0;
    b2.req1_valid = 1'b0; b2.req1_we = 1'b0; b2.req1_addr = '0; b2.req1_wdata = '0;
    b1.req0_valid = 1'b0; b1.req0_we = 1'b0; b1.req0_addr = '0; b1.req0_wdata = '0;
    b1.req1_valid = 1'b0; b1.req1_we = 1'b0; b1.req1_addr = '0; b1.req1_wdata = '0;
    b4.req0_valid = 1'b0; b4.req0_we = 1'b0; b4.req0_addr = '0; b4.req0_wdata = '0;
    b4.req1_valid = 1'b0; b4.req1_we = 1'b0; b4.req1_addr = '0; b4.req1_wdata = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_cpu_read();
    test_loader_write();
    test_round_robin();
    test_reset_abort();
    test_addr_change();
    test_latency_sweep();
    repeat (4) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 The block SHALL have parameter MEM_LATENCY, default 2, legal range 1..4: cycles from mem_en to valid mem_rdata.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req0_valid/req0_we  input  1 each  CPU memory-stage request and write-enable (requester 0).
REQ-007 req0_addr  input  ADDR_WIDTH, and req0_wdata  input  DATA_WIDTH  CPU request address and write data.
REQ-008 req0_ready  output  1  CPU request accepted this cycle.
REQ-009 rsp0_valid  output  1, and rsp0_rdata  output  DATA_WIDTH  CPU completion pulse and read data.
REQ-010 req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as REQ-006..009 for the loader/debug port (requester 1).
REQ-011 cpu_stall  output  1  equals req0_valid AND NOT req0_ready; drives the pipeline stall.
REQ-012 mem_en/mem_we  output  1 each, mem_addr  output  ADDR_WIDTH, mem_wdata  output  DATA_WIDTH, mem_rdata  input  DATA_WIDTH  single shared data memory port.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; only one transaction SHALL be in flight.
REQ-014 reqN_ready SHALL be high only in IDLE, for at most one requester per cycle; acceptance = valid AND ready at a rising edge (cycle T).
REQ-015 Arbitration: single valid requester is granted; both valid -> grant the requester not granted last (round-robin pointer last_gnt).
REQ-016 On acceptance the block SHALL latch we/addr/wdata and grant id, update last_gnt, and enter ISSUE.
REQ-017 ISSUE (cycle T+1): mem_en=1, mem_we/mem_addr/mem_wdata from latched values; exactly one cycle; then WAIT.
REQ-018 WAIT SHALL last MEM_LATENCY cycles (T+2..T+1+MEM_LATENCY), mem_en=0; mem_rdata sampled on last WAIT edge.
REQ-019 RESP (cycle T+2+MEM_LATENCY): rsp_valid of granted requester pulses for one cycle; rsp_rdata = sampled data for reads, 0 for writes; then IDLE.
REQ-020 rspN_rdata SHALL hold its value until the next response to that requester; rsp of the non-granted requester SHALL stay 0.
REQ-021 Requesters SHALL hold valid/we/addr/wdata stable while valid AND NOT ready; the block SHALL ignore changes after acceptance.
REQ-022 Requests arriving in ISSUE/WAIT/RESP SHALL wait; earliest next acceptance is T+3+MEM_LATENCY.
REQ-023 A requester dropping valid before acceptance SHALL cause no memory access.
REQ-024 mem_en SHALL never be high outside ISSUE; mem_we SHALL be 0 whenever mem_en is 0.

Reset
REQ-025 rst high at an edge SHALL force IDLE, last_gnt=1 (requester 0 wins the first tie), all outputs 0, rspN_rdata 0.
REQ-026 Reset mid-transaction SHALL abort it: no rsp pulse, no further mem_en; any ISSUE write already performed is not undone.
REQ-027 While rst is high, reqN_ready SHALL be 0 and cpu_stall SHALL equal req0_valid.

Verification (MEM_LATENCY=2)
REQ-028 Single CPU read, addr 0x10, mem_rdata 0xDEADBEEF at T+3 -> req0_ready at T, mem_en at T+1, rsp0_valid at T+4 with 0xDEADBEEF.
REQ-029 Both requesters valid from reset -> grant order 0,1,0,1; acceptances 5 cycles apart; cpu_stall high while req0 waits.
REQ-030 Loader write addr 0x20 data 0x55 -> mem_en=mem_we=1, mem_addr 0x20, mem_wdata 0x55 at T+1 only; rsp1_valid at T+4, rsp1_rdata 0.
REQ-031 rst asserted at T+2 of a read -> no rsp0_valid, mem_en 0, FSM IDLE; after release, new request accepted first cycle.
REQ-032 req0 changes addr during WAIT -> mem_addr unchanged; the changed request is served as a separate transaction at T+5.
REQ-033 MEM_LATENCY=1 and 4 sweep -> rsp at T+3 and T+6 respectively, single mem_en pulse each.
